// File: rtl/cdc_2phase_rx_fifo.sv
// Receiving half of a two-phase req/ack CDC link with an elastic FIFO.
// Optional transfer counter enabled by defining CDC_2PHASE_RX_STATS_EN.
module cdc_2phase_rx_fifo #(
  parameter type T           = logic,
  parameter int  DEPTH       = 4,
  parameter int  SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    async_req_i,
  input  T                        async_data_i,
  output logic                    async_ack_o,
  output T                        dst_data_o,
  output logic                    dst_valid_o,
  input  logic                    dst_ready_i,
  output logic [$clog2(DEPTH):0]  fill_o
`ifdef CDC_2PHASE_RX_STATS_EN
  ,
  output logic [15:0]             stat_xfer_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cdc_2phase_rx_fifo: DEPTH must be a power of two >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cdc_2phase_rx_fifo: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            fill_q, fill_d;
  logic                   ack_q, ack_d;
  T                       mem_q [DEPTH];
  T                       mem_d [DEPTH];

  logic req_synced;
  logic pending;
  logic full;
  logic push;
  logic pop;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], async_req_i};
    req_synced = sync_q[SYNC_STAGES-1];
    pending    = (req_synced != ack_q);
    // Registered count only: a pop this cycle never frees a slot for a push.
    full       = (fill_q == FULL_CNT);
    push       = pending && !full && !clear_i;
    pop        = dst_valid_o && dst_ready_i && !clear_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ack_d    = ack_q;
    mem_d    = mem_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      ack_d    = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = async_data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
        ack_d           = ~ack_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   fill_d = fill_q + (AW+1)'(1);
        2'b01:   fill_d = fill_q - (AW+1)'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ack_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ack_q    <= ack_d;
    end
  end

  // Storage holds no control meaning, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign async_ack_o = ack_q;
  assign dst_data_o  = mem_q[rd_ptr_q];
  assign dst_valid_o = (fill_q != '0);
  assign fill_o      = fill_q;

`ifdef CDC_2PHASE_RX_STATS_EN
  logic [15:0] stat_xfer_cnt_q, stat_xfer_cnt_d;

  always_comb begin
    stat_xfer_cnt_d = stat_xfer_cnt_q;
    if (clear_i) begin
      stat_xfer_cnt_d = '0;
    end else if (push) begin
      stat_xfer_cnt_d = stat_xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_xfer_cnt_q <= '0;
    end else begin
      stat_xfer_cnt_q <= stat_xfer_cnt_d;
    end
  end

  assign stat_xfer_cnt_o = stat_xfer_cnt_q;
`endif

endmodule

// File: tb/tb_cdc_2phase_rx_fifo.sv
// Randomized self-checking bench for cdc_2phase_rx_fifo with a queue-based reference.
module tb_cdc_2phase_rx_fifo;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       req = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       ack;
  logic [7:0] dout;
  logic       valid;
  logic [2:0] fill;
`ifdef CDC_2PHASE_RX_STATS_EN
  logic [15:0] stat;
  int unsigned m_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdc_2phase_rx_fifo #(
    .T           (logic [7:0]),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .async_req_i  (req),
    .async_data_i (data),
    .async_ack_o  (ack),
    .dst_data_o   (dout),
    .dst_valid_o  (valid),
    .dst_ready_i  (ready),
    .fill_o       (fill)
`ifdef CDC_2PHASE_RX_STATS_EN
    ,
    .stat_xfer_cnt_o (stat)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a request seen SYNC edges after it is driven is stored once,
  // if there is room and no clear; the queue holds the words in arrival order.
  bit         m_init = 1'b0;
  bit         m_ack;
  bit         m_hist[$];
  bit         m_synced;
  logic [7:0] m_q[$];
  logic [7:0] got_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_ack = 1'b0;
      m_q.delete();
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
`ifdef CDC_2PHASE_RX_STATS_EN
      m_cnt = 0;
`endif
      m_init = 1'b1;
    end else if (m_init) begin
      m_synced = m_hist.pop_front();
      m_hist.push_back(req);
      if (valid && ready && !clear) got_q.push_back(dout);
      if (clear) begin
        m_ack = 1'b0;
        m_q.delete();
`ifdef CDC_2PHASE_RX_STATS_EN
        m_cnt = 0;
`endif
      end else begin
        bit was_full;
        was_full = (m_q.size() == DEPTH);
        if (m_q.size() > 0 && ready) void'(m_q.pop_front());
        if (m_synced != m_ack && !was_full) begin
          m_q.push_back(data);
          m_ack = ~m_ack;
`ifdef CDC_2PHASE_RX_STATS_EN
          m_cnt = (m_cnt + 1) % 65536;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("valid", 32'(valid), 32'(m_q.size() > 0));
      chk("fill", 32'(fill), 32'(m_q.size()));
      if (m_q.size() > 0) chk("data", 32'(dout), 32'(m_q[0]));
`ifdef CDC_2PHASE_RX_STATS_EN
      chk("stat", 32'(stat), m_cnt);
`endif
    end
  end

  // Two-phase source: new word only once the previous one is acknowledged.
  logic [7:0] src_words[$];

  task automatic cyc();
    @(negedge clk);
    if (src_words.size() > 0 && ack == req) begin
      data = src_words.pop_front();
      req  = ~req;
    end
  endtask

  task automatic do_clear(input bit check);
    req   = 1'b0;
    clear = 1'b1;
    src_words.delete();
    @(negedge clk);
    if (check) begin
      chk("clr_fill", 32'(fill), 32'd0);
      chk("clr_valid", 32'(valid), 32'd0);
      chk("clr_ack", 32'(ack), 32'd0);
    end
    repeat (SYNC) @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_fill(input string name, input int target);
    int n = 0;
    while (fill !== 3'(target) && n < 100) begin
      cyc();
      n++;
    end
    chk(name, 32'(fill), 32'(target));
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit slow;
    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    rst = 1'b0;

    // Single transfer and its latency
    data = 8'hA5;
    req  = 1'b1;
    repeat (SYNC) @(negedge clk);
    chk("lat_no_early_ack", 32'(ack), 32'd0);
    @(negedge clk);
    chk("single_ack", 32'(ack), 32'd1);
    chk("single_valid", 32'(valid), 32'd1);
    chk("single_data", 32'(dout), 32'hA5);
    chk("single_fill", 32'(fill), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("single_pop_fill", 32'(fill), 32'd0);

    // Backpressure: six words into a four-deep FIFO
    got_q.delete();
    for (int i = 1; i <= 6; i++) src_words.push_back(8'(i));
    repeat (30) cyc();
    chk("bp_fill", 32'(fill), 32'd4);
    chk("bp_ack", 32'(ack), 32'd1);
    chk("bp_fifth_unacked", 32'(req != ack), 32'd1);
    chk("bp_sent", 32'(src_words.size()), 32'd1);
    ready = 1'b1;
    repeat (40) cyc();
    ready = 1'b0;
    chk("bp_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) chk("bp_order", 32'(got_q[i]), 32'(i + 1));

    // Simultaneous push and pop at fill 2
    got_q.delete();
    src_words.push_back(8'h10);
    src_words.push_back(8'h11);
    wait_fill("pp_pre_fill", 2);
    repeat (10) cyc();
    data = 8'h12;
    req  = ~req;
    repeat (SYNC) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("pp_fill", 32'(fill), 32'd2);
    chk("pp_head", 32'(dout), 32'h11);
    ready = 1'b1;
    repeat (10) cyc();
    ready = 1'b0;
    chk("pp_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("pp_order", 32'(got_q[i]), 32'(8'h10 + i));

    // Clear mid-operation at fill 3
    src_words.push_back(8'h21);
    src_words.push_back(8'h22);
    src_words.push_back(8'h23);
    wait_fill("clr_pre_fill", 3);
    repeat (10) cyc();
    chk("clr_pre_ack", 32'(ack), 32'd1);
    do_clear(1'b1);
    got_q.delete();
    src_words.push_back(8'h3C);
    repeat (15) cyc();
    ready = 1'b1;
    repeat (5) cyc();
    ready = 1'b0;
    chk("clr_new_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("clr_new_data", 32'(got_q[0]), 32'h3C);

`ifdef CDC_2PHASE_RX_STATS_EN
    do_clear(1'b0);
    chk("stat_clear", 32'(stat), 32'd0);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) src_words.push_back(8'($urandom));
    repeat (40) cyc();
    chk("stat_five", 32'(stat), 32'd5);
    #1;
    force dut.stat_xfer_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    #1;
    release dut.stat_xfer_cnt_q;
    src_words.push_back(8'h77);
    repeat (10) cyc();
    chk("stat_wrap", 32'(stat), 32'd0);
    do_clear(1'b0);
    chk("stat_clear2", 32'(stat), 32'd0);
    ready = 1'b0;
`endif

    // Randomized traffic with occasional clears and resets
    slow = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (i % 200 == 0) slow = ~slow;
      ready = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (src_words.size() == 0 && $urandom_range(0, 3) == 0)
        src_words.push_back(8'($urandom));
      if ($urandom_range(0, 299) == 0) do_clear(1'b1);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        req = 1'b0;
        src_words.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    end
    ready = 1'b1;
    repeat (20) cyc();
    chk("final_drain_fill", 32'(fill), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
